// File: rtl/noise_source.sv
// noise_source -- deterministic test-signal generator feeding the FIR's noise_in.
//
// Produces one m-bit signed sample per enabled cycle. Each sample is one of:
// zero, a triangle tone, LFSR noise, or tone+noise. The tone comes from a phase
// accumulator. The noise comes from a 16-bit Galois LFSR. When both are
// selected, their sum is saturated to m bits.
//
// The pipeline has two register stages:
//   stage 1 (on en) : gated tone and noise components, plus valid1
//   stage 2         : saturated sum into noise_out, plus sample_valid
//
// Ports
//   clk, rst_n    clock and asynchronous active-low reset
//   en            produce one sample this cycle
//   sync          synchronous clear of the phase accumulator (wins over en)
//   mode          00 zero, 01 tone, 10 noise, 11 tone+noise
//   phase_inc     unsigned phase step per enabled cycle
//   noise_shift   arithmetic right shift applied to the noise (0..3)
//   noise_out     signed sample
//   sample_valid  noise_out was updated this cycle (en delayed by two stages)
module noise_source #(
   parameter int          m       = 7,
   parameter int          PHASE_W = 16,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                sync,
   input  logic [1:0]          mode,
   input  logic [PHASE_W-1:0]  phase_inc,
   input  logic [1:0]          noise_shift,
   output logic signed [m-1:0] noise_out,
   output logic                sample_valid
);

   // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] TAPS     = 16'hB400;
   // Offset 2^(m-2) centres the folded ramp around zero.
   localparam logic [m-1:0] TONE_OFS = {2'b01, {(m-2){1'b0}}};

   typedef struct packed {
      logic signed [m-1:0] tone;
      logic signed [m-1:0] noise;
   } s1_t;

   logic [PHASE_W-1:0] phase;
   logic [15:0]        lfsr;
   logic [15:0]        lfsr_nx;
   logic [m-1:0]       p;
   logic [m-2:0]       f;
   logic signed [m-1:0] tone;
   logic signed [m-1:0] nraw;
   logic signed [m-1:0] noise;
   s1_t                s1;
   logic [1:0]         vld_pipe;   // [0] = valid1, [1] = sample_valid
   logic signed [m:0]  sum;
   logic signed [m-1:0] sat;

   // Tone: the top m phase bits are folded into a triangle.
   // The second half of the period counts back down.
   assign p    = phase[PHASE_W-1 -: m];
   assign f    = p[m-1] ? ~p[m-2:0] : p[m-2:0];
   assign tone = {1'b0, f} - TONE_OFS;

   // Noise: the low m LFSR bits are taken as a signed value, then scaled down.
   assign nraw  = lfsr[m-1:0];
   assign noise = nraw >>> noise_shift;

   assign lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);

   // The phase accumulator and the LFSR advance together on en.
   // sync clears only the phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= '0;
         lfsr  <= SEED_EFF;
      end else begin
         if (sync)    phase <= '0;
         else if (en) phase <= phase + phase_inc;
         if (en)      lfsr  <= lfsr_nx;
      end
   end

   // Stage 1 captures the pre-update phase and lfsr.
   // A component that mode does not select is captured as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= '0;
         vld_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[0], en};
         if (en) begin
            s1.tone  <= mode[0] ? tone  : '0;
            s1.noise <= mode[1] ? noise : '0;
         end
      end
   end

   // Stage 2: add at m+1 bits, then clamp.
   // Overflow shows up as a disagreement between the top two sum bits.
   assign sum = {s1.tone[m-1], s1.tone} + {s1.noise[m-1], s1.noise};

   always_comb begin
      sat = sum[m-1:0];
      if (sum[m] != sum[m-1])
         sat = sum[m] ? {1'b1, {(m-1){1'b0}}} : {1'b0, {(m-1){1'b1}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           noise_out <= '0;
      else if (vld_pipe[0]) noise_out <= sat;
   end

   assign sample_valid = vld_pipe[1];

endmodule

// File: tb/tb_noise_source.sv
// Bench for noise_source.
// Two instances share the stimulus: dut_a uses the default seed, dut_b uses
// seed 0x0040. A per-cycle integer model predicts sample_valid and noise_out
// for both instances. Table vectors and short sequences check hand-computed
// values.
module tb_noise_source;
   localparam int M = 7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic sync = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [1:0]  noise_shift = 2'b00;
   logic [15:0] phase_inc = 16'h0000;
   logic signed [M-1:0] out_a, out_b;
   logic val_a, val_b;

   always #5 clk = ~clk;

   noise_source #(.m(M), .PHASE_W(16), .SEED(16'hACE1)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .mode(mode),
      .phase_inc(phase_inc), .noise_shift(noise_shift),
      .noise_out(out_a), .sample_valid(val_a));

   noise_source #(.m(M), .PHASE_W(16), .SEED(16'h0040)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .mode(mode),
      .phase_inc(phase_inc), .noise_shift(noise_shift),
      .noise_out(out_b), .sample_valid(val_b));

   int tests = 0;
   int fails = 0;

   // model state
   int          mph;
   logic [15:0] la, lb;
   logic        p1v, ev;
   int          p1a, p1b, ea, eb;
   int          capa[$];
   int          capb[$];

   typedef struct {
      logic        b;      // 1: check dut_b (seed 0x0040), 0: dut_a
      logic [1:0]  md;
      logic [1:0]  sh;
      logic [15:0] inc;
      int          e0;
      int          e1;
   } vec_t;
   vec_t vecs[10];

   function automatic int tone_of(int ph);
      int pp;
      pp = (ph >> 9) & 127;
      return (pp < 64) ? pp - 32 : 95 - pp;
   endfunction

   function automatic int noise_of(logic [15:0] l, logic [1:0] sh);
      int v;
      v = int'(l[6:0]);
      if (v >= 64) v -= 128;
      return v >>> sh;
   endfunction

   function automatic logic [15:0] lfsr_next(logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   function automatic int samp(logic [1:0] md, int t, int n);
      int s;
      s = (md[0] ? t : 0) + (md[1] ? n : 0);
      if (s > 63)  s = 63;
      if (s < -64) s = -64;
      return s;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic mreset();
      mph = 0; la = 16'hACE1; lb = 16'h0040;
      p1v = 1'b0; p1a = 0; p1b = 0; ev = 1'b0; ea = 0; eb = 0;
      capa.delete(); capb.delete();
   endtask

   // One clock cycle with the given en and sync; checks both instances after the edge.
   task automatic cyc(input logic e, input logic s);
      logic nv;
      int   na, nb, t;
      en = e; sync = s;
      nv = e; na = 0; nb = 0;
      if (e) begin
         t  = tone_of(mph);
         na = samp(mode, t, noise_of(la, noise_shift));
         nb = samp(mode, t, noise_of(lb, noise_shift));
      end
      @(posedge clk); #1;
      ev = p1v;
      if (p1v) begin ea = p1a; eb = p1b; end
      p1v = nv;
      if (nv) begin p1a = na; p1b = nb; end
      if (s)      mph = 0;
      else if (e) mph = (mph + int'(phase_inc)) & 32'hFFFF;
      if (e) begin la = lfsr_next(la); lb = lfsr_next(lb); end
      chk("valid_a", int'(val_a), int'(ev));
      chk("valid_b", int'(val_b), int'(ev));
      chk("out_a", int'(out_a), ea);
      chk("out_b", int'(out_b), eb);
      if (val_a) capa.push_back(int'(out_a));
      if (val_b) capb.push_back(int'(out_b));
      en = 1'b0; sync = 1'b0;
   endtask

   task automatic do_reset();
      en = 1'b0; sync = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      chk("reset_out", int'(out_a), 0);
      chk("reset_valid", int'(val_a), 0);
      rst_n = 1'b1;
      mreset();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ref_q[$];
      int n;
      logic e;
      vecs[0] = '{1'b0, 2'b10, 2'd0, 16'h0000, -31, -16};
      vecs[1] = '{1'b0, 2'b10, 2'd2, 16'h0000,  -8,  -4};
      vecs[2] = '{1'b0, 2'b10, 2'd1, 16'h0000, -16,  -8};
      vecs[3] = '{1'b0, 2'b00, 2'd0, 16'h0200,   0,   0};
      vecs[4] = '{1'b0, 2'b01, 2'd0, 16'h0200, -32, -31};
      vecs[5] = '{1'b0, 2'b11, 2'd0, 16'h0200, -63, -47};
      vecs[6] = '{1'b0, 2'b11, 2'd0, 16'h8000, -63,  15};
      vecs[7] = '{1'b1, 2'b11, 2'd0, 16'h8000, -64,  63};
      vecs[8] = '{1'b1, 2'b10, 2'd3, 16'h0000,  -8,   4};
      vecs[9] = '{1'b1, 2'b01, 2'd0, 16'h8000, -32,  31};

      // Reset held with en high, then released with en low.
      mreset();
      rst_n = 1'b0; en = 1'b1; mode = 2'b11; phase_inc = 16'h0200;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_hold_out", int'(out_a), 0);
         chk("rst_hold_valid", int'(val_a), 0);
      end
      rst_n = 1'b1; en = 1'b0;
      repeat (5) cyc(1'b0, 1'b0);

      // Table vectors: the first two samples after reset.
      for (int i = 0; i < 10; i++) begin
         do_reset();
         mode = vecs[i].md; noise_shift = vecs[i].sh; phase_inc = vecs[i].inc;
         cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
         if (vecs[i].b) begin
            chk($sformatf("vec%0d_count", i), capb.size(), 2);
            chk($sformatf("vec%0d_s0", i), capb[0], vecs[i].e0);
            chk($sformatf("vec%0d_s1", i), capb[1], vecs[i].e1);
         end else begin
            chk($sformatf("vec%0d_count", i), capa.size(), 2);
            chk($sformatf("vec%0d_s0", i), capa[0], vecs[i].e0);
            chk($sformatf("vec%0d_s1", i), capa[1], vecs[i].e1);
         end
      end

      // Tone: full period, latency, and the doubled peak.
      do_reset();
      mode = 2'b01; phase_inc = 16'h0200; noise_shift = 2'd0;
      cyc(1'b1, 1'b0);
      chk("tone_lat_edge1", int'(val_a), 0);
      cyc(1'b1, 1'b0);
      chk("tone_lat_edge2", int'(val_a), 1);
      repeat (127) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      chk("tone_count", capa.size(), 129);
      chk("tone_0", capa[0], -32);
      chk("tone_1", capa[1], -31);
      chk("tone_63", capa[63], 31);
      chk("tone_64", capa[64], 31);
      chk("tone_65", capa[65], 30);
      chk("tone_127", capa[127], -32);
      chk("tone_128", capa[128], -32);

      // Mid-stream reset clears the outputs before the next edge.
      repeat (3) cyc(1'b1, 1'b0);
      chk("mid_pre_valid", int'(val_a), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out", int'(out_a), 0);
      chk("mid_rst_valid", int'(val_a), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mreset();
      cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
      chk("mid_restart_count", capa.size(), 2);
      chk("mid_restart_s0", capa[0], -32);
      chk("mid_restart_s1", capa[1], -31);

      // Gating: the gated run must reproduce the continuous sequence.
      do_reset();
      mode = 2'b11; phase_inc = 16'h0200; noise_shift = 2'd1;
      repeat (40) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      ref_q = capa;
      do_reset();
      n = 0;
      while (n < 40) begin
         e = 1'($urandom_range(0, 1));
         cyc(e, 1'b0);
         if (e) n++;
      end
      cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
      chk("gate_count", capa.size(), ref_q.size());
      for (int i = 0; i < ref_q.size(); i++)
         chk($sformatf("gate_s%0d", i), capa[i], ref_q[i]);

      // Sync with en: that sample uses the old phase, the next one uses phase 0.
      do_reset();
      mode = 2'b01; phase_inc = 16'h0200; noise_shift = 2'd0;
      repeat (20) cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      repeat (3) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      chk("sync_old", capa[20], -12);
      chk("sync_next", capa[21], -32);
      chk("sync_next2", capa[22], -31);
      // Sync with en low: the phase clears without producing a sample.
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      chk("sync_idle_count", capa.size(), 25);
      chk("sync_idle", capa[24], -32);

      // Random: the model checks every cycle, including mode/step changes while idle.
      do_reset();
      repeat (10000) begin
         mode        = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
         noise_shift = 2'($urandom);
         phase_inc   = 16'($urandom);
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/noise_source.md
# noise_source

Test-signal generator that drives the `noise_in` input of the team's 11-tap low-pass FIR filter. It produces an m-bit signed sample stream made of one of the following: zero, a triangle tone from a phase accumulator, LFSR pseudo-random noise, or tone plus noise with saturation. It sits upstream of the filter on the same clock. One sample is produced per enabled cycle, so the filter sees a deterministic, reproducible stimulus.

## Interface
- m, 7: sample width (signed two's complement); must match the filter's m; legal range 4..16
- PHASE_W, 16: phase accumulator width; must be ≥ m
- SEED, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  produce one sample this cycle
- sync  in  1  synchronous clear of the phase accumulator
- mode  in  2  00 zero, 01 tone, 10 noise, 11 tone+noise
- phase_inc  in  PHASE_W  unsigned phase step per enabled cycle
- noise_shift  in  2  arithmetic right shift applied to noise (0..3)
- noise_out  out  m  signed sample; connects to the filter's noise_in
- sample_valid  out  1  noise_out was updated this cycle

One clock domain. Reset is asynchronous and active-low. Ports are named clk and rst_n.

## Operation
- **Phase accumulator** `phase[PHASE_W-1:0]`:
  - next = sync ? 0 : en ? phase + phase_inc (mod 2^PHASE_W) : phase.
  - sync has priority over en.
- **Tone**:
  - p = phase[PHASE_W-1 -: m], unsigned.
  - f = p[m-1] ? ~p[m-2:0] : p[m-2:0].
  - tone = f − 2^(m-2), signed; range [−2^(m-2), 2^(m-2)−1], which is −32..31 for m=7.
- **LFSR**: 16-bit Galois, right-shifting.
  - next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
  - Advances only when en=1. sync does not affect it.
- **Noise**: lfsr[m-1:0] interpreted as signed m-bit, then arithmetic-shifted right (>>>) by noise_shift.
- **Stage 1** (on en):
  - Registers tone_r and noise_r from the current, pre-update phase and lfsr.
  - mode gates each component: a component not selected is registered as 0.
  - Registers mode and valid1.
- **Stage 2**:
  - sum = tone_r + noise_r at m+1 bits, saturated to [−2^(m-1), 2^(m-1)−1].
  - When valid1=1, noise_out ← saturated sum and sample_valid ← 1.
  - Otherwise noise_out holds its value and sample_valid ← 0.
- mode, noise_shift and phase_inc are sampled only on en cycles and may change on any cycle.

## Timing
- **Reset values** (rst_n low, asynchronous):
  - phase=0, lfsr=SEED (0→1).
  - tone_r=0, noise_r=0, valid1=0.
  - noise_out=0, sample_valid=0.
- **Latency**: en high at edge k means noise_out and sample_valid=1 update at edge k+1. Throughput is one sample per clock.
- sample_valid is en delayed by exactly 2 register stages: it pulses once per enabled cycle and never fills gaps.
- **en low**: phase, lfsr and noise_out hold. The next enabled sample continues the sequence with no skipped value.
- **sync and en in the same cycle**: this sample uses the old phase. The following sample uses phase 0, giving tone −2^(m-2).
- **Phase wrap**: modulo 2^PHASE_W with no glitch. For p=2^(m-1), tone = 2^(m-2)−1, so the peak value appears on two consecutive samples.
- **rst_n asserted mid-stream**: outputs clear immediately. Any in-flight stage-1 sample is discarded. After release, the sequence restarts from SEED and phase 0.

## Test plan
1. **Reset.** Hold rst_n low for 3 cycles with en=1. Then release with en=0 for 5 cycles. Required: noise_out=0 and sample_valid=0 throughout. Asserting rst_n mid-stream clears the outputs within the same cycle, before the next clock edge.
2. **Tone.** m=7, PHASE_W=16, mode=01, phase_inc=16'h0200, en held high. Required:
   - Valid samples run −32, −31, …, 31, 31, 30, …, −32.
   - Period is 128 samples.
   - The first valid sample appears 2 edges after en rises.
3. **Noise.** SEED=16'hACE1, mode=10, noise_shift=0. Required: first two samples are −31 and −16 (lfsr 0xACE1, then 0xE270). Repeating with noise_shift=2 gives −8 as the first sample.
4. **Saturation.** SEED=16'h0040, mode=11, phase_inc=16'h8000. Required:
   - Sample 1: −32 + −64 saturates to −64.
   - Sample 2: 31 + 32 = 63, no wrap.
   - A bench model checks clamp(tone+noise) over 10k random samples.
5. **Gating and sync.**
   - Toggle en in a pseudo-random pattern. Required: the valid-sample sequence is identical to the continuous-en run, and sample_valid pulses equal en delayed by 2.
   - Pulse sync with en=1 mid-tone. Required: the sample after the pulse is −32.
